rf_fill: RTL

Maintains the per-core register array that the register-file read decoder unpacks, and drives it as one packed vector. When a core moves its memory pointer, the block writes back a modified value if there is one and then fetches the new cell. All cores share a single memory port, granted round-robin. It sits between the cores' pointer/value update requests and the tape memory.

---
 rtl/rf_fill.sv | 153 +++++++++++++++
 1 files changed

// File: rtl/rf_fill.sv
// Per-core register array with a shared, round-robin writeback/fetch engine
// that keeps each core's cached cell in step with the tape memory.
module rf_fill #(
  parameter int NCORES = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [NCORES-1:0]      set_ptr_valid,
  input  logic [NCORES*16-1:0]   set_ptr,
  input  logic [NCORES-1:0]      wr_valid,
  input  logic [NCORES*16-1:0]   wr_val,
  output logic [NCORES*35-1:0]   rf_out,
  output logic                   mem_req,
  output logic                   mem_we,
  output logic [15:0]            mem_addr,
  output logic [15:0]            mem_wdata,
  input  logic                   mem_ack,
  input  logic [15:0]            mem_rdata
);

  // state    | meaning
  // IDLE     | no service in flight; arbitrate among retrieving cores
  // WB       | writing the granted core's locked value to wb_tag
  // FETCH    | reading the granted core's new cell at tag
  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_WB    = 2'd1;
  localparam logic [1:0] ST_FETCH = 2'd2;

  localparam int IW = (NCORES > 1) ? $clog2(NCORES) : 1;

  logic [1:0]        state_q, state_d;
  logic [IW-1:0]     gnt_q, gnt_d;
  logic [IW-1:0]     rr_q, rr_d;
  logic [NCORES-1:0] valid_q, valid_d;
  logic [NCORES-1:0] retr_q, retr_d;
  logic [NCORES-1:0] locked_q, locked_d;
  logic [15:0]       tag_q    [NCORES];
  logic [15:0]       tag_d    [NCORES];
  logic [15:0]       val_q    [NCORES];
  logic [15:0]       val_d    [NCORES];
  logic [15:0]       wb_tag_q [NCORES];
  logic [15:0]       wb_tag_d [NCORES];

  logic              pick_found;
  logic [IW-1:0]     pick;
  logic [IW-1:0]     idx;

  always_comb begin
    state_d    = state_q;
    gnt_d      = gnt_q;
    rr_d       = rr_q;
    valid_d    = valid_q;
    retr_d     = retr_q;
    locked_d   = locked_q;
    tag_d      = tag_q;
    val_d      = val_q;
    wb_tag_d   = wb_tag_q;
    pick_found = 1'b0;
    pick       = '0;
    idx        = '0;

    // Write is applied before the move so a same-cycle write is what gets written back.
    for (int k = 0; k < NCORES; k++) begin
      if (wr_valid[k] && valid_q[k]) begin
        val_d[k]    = wr_val[k*16 +: 16];
        locked_d[k] = 1'b1;
      end
      if (set_ptr_valid[k] && !retr_q[k]) begin
        wb_tag_d[k] = tag_q[k];
        tag_d[k]    = set_ptr[k*16 +: 16];
        valid_d[k]  = 1'b0;
        retr_d[k]   = 1'b1;
      end
    end

    case (state_q)
      ST_IDLE: begin
        for (int i = 0; i < NCORES; i++) begin
          idx = IW'((int'(rr_q) + i) % NCORES);
          if (!pick_found && retr_q[idx]) begin
            pick_found = 1'b1;
            pick       = idx;
          end
        end
        if (pick_found) begin
          gnt_d   = pick;
          state_d = locked_q[pick] ? ST_WB : ST_FETCH;
        end
      end
      ST_WB: begin
        if (mem_ack) begin
          locked_d[gnt_q] = 1'b0;
          state_d         = ST_FETCH;
        end
      end
      ST_FETCH: begin
        if (mem_ack) begin
          val_d[gnt_q]   = mem_rdata;
          valid_d[gnt_q] = 1'b1;
          retr_d[gnt_q]  = 1'b0;
          rr_d           = IW'((int'(gnt_q) + 1) % NCORES);
          state_d        = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      gnt_q    <= '0;
      rr_q     <= '0;
      valid_q  <= '0;
      retr_q   <= '0;
      locked_q <= '0;
      for (int k = 0; k < NCORES; k++) begin
        tag_q[k]    <= '0;
        val_q[k]    <= '0;
        wb_tag_q[k] <= '0;
      end
    end else begin
      state_q  <= state_d;
      gnt_q    <= gnt_d;
      rr_q     <= rr_d;
      valid_q  <= valid_d;
      retr_q   <= retr_d;
      locked_q <= locked_d;
      tag_q    <= tag_d;
      val_q    <= val_d;
      wb_tag_q <= wb_tag_d;
    end
  end

  // Granted core's fields are frozen during service, so these stay stable until after ack.
  always_comb begin
    mem_req   = (state_q != ST_IDLE);
    mem_we    = (state_q == ST_WB);
    mem_addr  = '0;
    mem_wdata = '0;
    if (state_q == ST_WB) begin
      mem_addr  = wb_tag_q[gnt_q];
      mem_wdata = val_q[gnt_q];
    end else if (state_q == ST_FETCH) begin
      mem_addr  = tag_q[gnt_q];
    end
  end

  for (genvar g = 0; g < NCORES; g++) begin : g_rf
    assign rf_out[g*35 +: 35] = {valid_q[g], retr_q[g], locked_q[g], tag_q[g], val_q[g]};
  end

endmodule
